// File: rtl/grid_cmd_engine.sv
// Cell command engine: executes WRITE/READ/FILL/CLEAR commands against a
// single-port grid cell RAM and returns one registered response per command.
module grid_cmd_engine #(
  parameter int GRID_ROWS = 16,
  parameter int GRID_COLS = 16,
  parameter int CELL_W    = 4,
  parameter int ADDR_W    = 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [7:0]        cmd_row,
  input  logic [7:0]        cmd_col,
  input  logic [CELL_W-1:0] cmd_data,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [CELL_W-1:0] ram_wdata,
  input  logic [CELL_W-1:0] ram_rdata,
  output logic              rsp_valid,
  output logic [CELL_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  // Handshake: a command transfers on a rising ACLK edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high exactly when the FSM is idle,
  // and every cmd_* field is sampled only on that transfer edge.

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_FILL  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam int                N_CELLS   = GRID_ROWS * GRID_COLS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CELLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_REQ,
    S_RD_WAIT,
    S_FILL,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CELL_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                re_q, re_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [CELL_W-1:0]   rsp_data_q, rsp_data_d;

  logic [16:0]         full_addr;
  logic [ADDR_W-1:0]   cell_addr;
  logic                out_of_range;

  // Full-width row*cols+col, truncated to the RAM address width afterwards.
  assign full_addr    = 17'(cmd_row) * 17'(GRID_COLS) + 17'(cmd_col);
  assign cell_addr    = full_addr[ADDR_W-1:0];
  assign out_of_range = (9'(cmd_row) >= 9'(GRID_ROWS)) || (9'(cmd_col) >= 9'(GRID_COLS));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      re_q        <= re_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Outputs are computed for the state being entered so they line up with it.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if ((cmd_op == OP_WRITE || cmd_op == OP_READ) && out_of_range) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            case (cmd_op)
              OP_WRITE: begin
                state_d = S_WRITE;
                addr_d  = cell_addr;
                wdata_d = cmd_data;
                we_d    = 1'b1;
              end
              OP_READ: begin
                state_d = S_RD_REQ;
                addr_d  = cell_addr;
                re_d    = 1'b1;
              end
              OP_FILL: begin
                state_d = S_FILL;
                addr_d  = '0;
                wdata_d = cmd_data;
                we_d    = 1'b1;
              end
              OP_CLEAR: begin
                state_d = S_FILL;
                addr_d  = '0;
                wdata_d = '0;
                we_d    = 1'b1;
              end
            endcase
          end
        end
      end
      S_WRITE: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
      end
      S_RD_REQ: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        rsp_data_d  = ram_rdata;
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
      end
      S_FILL: begin
        // ram_addr doubles as the fill counter; the last cell ends the sweep.
        if (addr_q == LAST_ADDR) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          we_d   = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign ram_we    = we_q;
  assign ram_re    = re_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_grid_cmd_engine.sv
// Directed bench for grid_cmd_engine: behavioural cell RAM plus one task per scenario.
module tb_grid_cmd_engine;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_row;
  logic [7:0] cmd_col;
  logic [3:0] cmd_data;
  logic       ram_we;
  logic       ram_re;
  logic [7:0] ram_addr;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] mem [256];

  grid_cmd_engine #(
    .GRID_ROWS(16), .GRID_COLS(16), .CELL_W(4), .ADDR_W(8)
  ) dut (
    .ACLK(clk), .ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_data(cmd_data),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM model, read data one cycle after ram_re
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: presents a command at a negedge, returns at the negedge of cycle 1
  task automatic issue(input logic [1:0] op, input logic [7:0] row, input logic [7:0] col,
                       input logic [3:0] data);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_row = row; cmd_col = col; cmd_data = data;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #200;
    rst = 1'b0;
    #1;
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (ram_we !== 1'b0 || ram_re !== 1'b0) begin n_fail++; $display("FAIL reset_ram we=%b re=%b exp=0/0", ram_we, ram_re); end
    n_tests++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp valid=%b err=%b exp=0/0", rsp_valid, rsp_err); end
    n_tests++; if (rsp_data !== 4'h0) begin n_fail++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
  endtask

  task automatic test_write_read();
    issue(2'd0, 8'd3, 8'd5, 4'hA);
    n_tests++; if (ram_we !== 1'b1 || ram_re !== 1'b0) begin n_fail++; $display("FAIL wr_c1_we we=%b re=%b exp=1/0", ram_we, ram_re); end
    n_tests++; if (ram_addr !== 8'h35) begin n_fail++; $display("FAIL wr_c1_addr got=%h exp=35", ram_addr); end
    n_tests++; if (ram_wdata !== 4'hA) begin n_fail++; $display("FAIL wr_c1_wdata got=%h exp=a", ram_wdata); end
    n_tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL wr_c1_ctl rsp=%b rdy=%b busy=%b exp=0/0/1", rsp_valid, cmd_ready, busy); end
    @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL wr_c2_rsp rsp=%b err=%b we=%b exp=1/0/0", rsp_valid, rsp_err, ram_we); end
    @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_c3_idle rsp=%b rdy=%b exp=0/1", rsp_valid, cmd_ready); end
    issue(2'd1, 8'd3, 8'd5, 4'h0);
    n_tests++; if (ram_re !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 8'h35) begin n_fail++; $display("FAIL rd_c1 re=%b we=%b addr=%h exp=1/0/35", ram_re, ram_we, ram_addr); end
    @(negedge clk);
    n_tests++; if (ram_re !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_c2 re=%b rsp=%b exp=0/0", ram_re, rsp_valid); end
    @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rd_c3_rsp rsp=%b err=%b exp=1/0", rsp_valid, rsp_err); end
    n_tests++; if (rsp_data !== 4'hA) begin n_fail++; $display("FAIL rd_c3_data got=%h exp=a", rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_fill(input logic [1:0] op, input logic [3:0] data, input logic [3:0] exp_w);
    int cyc, we_cnt, bad_we, bad_rdy, rsp_cyc;
    cyc = 1; we_cnt = 0; bad_we = 0; bad_rdy = 0; rsp_cyc = 0;
    issue(op, 8'd9, 8'd9, data);
    while (cyc <= 300) begin
      if (ram_we) begin
        if (ram_addr !== 8'(cyc - 1) || ram_wdata !== exp_w || cyc > 256) bad_we++;
        we_cnt++;
      end
      if (ram_re) bad_we++;
      if (rsp_valid) begin rsp_cyc = cyc; break; end
      if (cmd_ready) bad_rdy++;
      @(negedge clk);
      cyc++;
    end
    n_tests++; if (we_cnt !== 256) begin n_fail++; $display("FAIL fill_op%0d_count got=%0d exp=256", op, we_cnt); end
    n_tests++; if (bad_we !== 0) begin n_fail++; $display("FAIL fill_op%0d_seq bad_cycles=%0d exp=0", op, bad_we); end
    n_tests++; if (rsp_cyc !== 257) begin n_fail++; $display("FAIL fill_op%0d_rsp_cycle got=%0d exp=257", op, rsp_cyc); end
    n_tests++; if (bad_rdy !== 0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL fill_op%0d_ctl ready_high=%0d err=%b exp=0/0", op, bad_rdy, rsp_err); end
    n_tests++; if (rsp_data !== 4'hA) begin n_fail++; $display("FAIL fill_op%0d_hold_data got=%h exp=a", op, rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_range();
    issue(2'd0, 8'd16, 8'd0, 4'h5);
    n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("FAIL rng_row16 rsp=%b err=%b we=%b exp=1/1/0", rsp_valid, rsp_err, ram_we); end
    @(negedge clk);
    n_tests++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL rng_row16_c2 rdy=%b rsp=%b we=%b exp=1/0/0", cmd_ready, rsp_valid, ram_we); end
    issue(2'd0, 8'd0, 8'd16, 4'h5);
    n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("FAIL rng_col16 rsp=%b err=%b we=%b exp=1/1/0", rsp_valid, rsp_err, ram_we); end
    issue(2'd1, 8'd16, 8'd3, 4'h0);
    n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || ram_re !== 1'b0) begin n_fail++; $display("FAIL rng_rd_row16 rsp=%b err=%b re=%b exp=1/1/0", rsp_valid, rsp_err, ram_re); end
    n_tests++; if (rsp_data !== 4'hA) begin n_fail++; $display("FAIL rng_rd_hold_data got=%h exp=a", rsp_data); end
    issue(2'd0, 8'd15, 8'd15, 4'hC);
    n_tests++; if (ram_we !== 1'b1 || ram_addr !== 8'hFF || ram_wdata !== 4'hC) begin n_fail++; $display("FAIL rng_last_wr we=%b addr=%h wd=%h exp=1/ff/c", ram_we, ram_addr, ram_wdata); end
    @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rng_last_wr_rsp rsp=%b err=%b exp=1/0", rsp_valid, rsp_err); end
    issue(2'd1, 8'd15, 8'd15, 4'h0);
    n_tests++; if (ram_re !== 1'b1 || ram_addr !== 8'hFF) begin n_fail++; $display("FAIL rng_last_rd re=%b addr=%h exp=1/ff", ram_re, ram_addr); end
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 4'hC) begin n_fail++; $display("FAIL rng_last_rd_rsp rsp=%b err=%b data=%h exp=1/0/c", rsp_valid, rsp_err, rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_holdoff();
    int cyc, we_cnt, bad, rsp_cyc;
    cyc = 1; we_cnt = 0; bad = 0; rsp_cyc = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_row = 8'd0; cmd_col = 8'd0; cmd_data = 4'h3;
    @(posedge clk);
    @(negedge clk);
    while (cyc <= 300) begin
      if (ram_re) bad++;
      if (ram_we) begin
        if (ram_addr !== 8'(cyc - 1) || ram_wdata !== 4'h3) bad++;
        we_cnt++;
      end
      if (cmd_ready) bad++;
      if (rsp_valid) begin rsp_cyc = cyc; break; end
      // Keep offering legal WRITE/READ commands with shifting fields
      cmd_op = 2'(cyc % 2); cmd_row = 8'(cyc % 16); cmd_col = 8'((cyc * 3) % 16); cmd_data = 4'(cyc);
      @(negedge clk);
      cyc++;
    end
    n_tests++; if (we_cnt !== 256 || bad !== 0) begin n_fail++; $display("FAIL hold_fill we_cnt=%0d bad=%0d exp=256/0", we_cnt, bad); end
    n_tests++; if (rsp_cyc !== 257) begin n_fail++; $display("FAIL hold_rsp_cycle got=%0d exp=257", rsp_cyc); end
    cmd_op = 2'd0; cmd_row = 8'd2; cmd_col = 8'd1; cmd_data = 4'h9;
    @(negedge clk);
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL hold_idle_ready got=%b exp=1", cmd_ready); end
    cmd_row = 8'd1; cmd_col = 8'd2; cmd_data = 4'h6;
    @(posedge clk);
    @(negedge clk);
    cmd_op = 2'd1; cmd_row = 8'd4; cmd_col = 8'd4;
    n_tests++; if (ram_we !== 1'b1 || ram_addr !== 8'h12 || ram_wdata !== 4'h6) begin n_fail++; $display("FAIL hold_accept_fields we=%b addr=%h wd=%h exp=1/12/6", ram_we, ram_addr, ram_wdata); end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_tests++; if (rsp_valid !== 1'b1 || ram_re !== 1'b0) begin n_fail++; $display("FAIL hold_wr_rsp rsp=%b re=%b exp=1/0", rsp_valid, ram_re); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || ram_re !== 1'b0) begin n_fail++; $display("FAIL hold_no_extra busy=%b re=%b exp=0/0", busy, ram_re); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_row = 8'd0; cmd_col = 8'd1; cmd_data = 4'h1;
    @(posedge clk);
    @(negedge clk);
    cmd_row = 8'd1; cmd_col = 8'd0; cmd_data = 4'h2;
    n_tests++; if (ram_we !== 1'b1 || ram_addr !== 8'h01 || ram_wdata !== 4'h1) begin n_fail++; $display("FAIL b2b_first we=%b addr=%h wd=%h exp=1/01/1", ram_we, ram_addr, ram_wdata); end
    @(negedge clk);
    n_tests++; if (ram_we !== 1'b0 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_c2 we=%b rsp=%b exp=0/1", ram_we, rsp_valid); end
    @(negedge clk);
    n_tests++; if (ram_we !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_c3 we=%b rdy=%b exp=0/1", ram_we, cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_tests++; if (ram_we !== 1'b1 || ram_addr !== 8'h10 || ram_wdata !== 4'h2) begin n_fail++; $display("FAIL b2b_second we=%b addr=%h wd=%h exp=1/10/2", ram_we, ram_addr, ram_wdata); end
    @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL b2b_second_rsp rsp=%b err=%b exp=1/0", rsp_valid, rsp_err); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_fill();
    int cyc, found, bad;
    cyc = 1; found = 0; bad = 0;
    issue(2'd2, 8'd0, 8'd0, 4'hF);
    while (cyc <= 300) begin
      if (ram_we && ram_addr == 8'h40) begin found = 1; break; end
      @(negedge clk);
      cyc++;
    end
    n_tests++; if (found !== 1) begin n_fail++; $display("FAIL mid_reach_40 found=%0d exp=1", found); end
    rst = 1'b1;
    #1;
    n_tests++; if (ram_we !== 1'b0 || ram_re !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_async we=%b re=%b busy=%b exp=0/0/0", ram_we, ram_re, busy); end
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || ram_we) bad++;
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid || ram_we || busy) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL mid_no_resume bad_cycles=%0d exp=0", bad); end
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got=%b exp=1", cmd_ready); end
    n_tests++; if (rsp_data !== 4'h0) begin n_fail++; $display("FAIL mid_rsp_data got=%h exp=0", rsp_data); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 4'h0;
    ram_rdata = 4'h0;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_row = 8'd0; cmd_col = 8'd0; cmd_data = 4'h0;
    test_reset();
    test_write_read();
    test_fill(2'd2, 4'h7, 4'h7);
    test_fill(2'd3, 4'h5, 4'h0);
    test_range();
    test_holdoff();
    test_back_to_back();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_cmd_engine.md
Name: grid_cmd_engine

Overview:
- Sits directly downstream of the grid_controller AXI4-Lite register slave.
- Consumes one decoded cell command at a time: write a cell, read a cell, fill the grid, or clear the grid.
- Executes each command against the single-port grid cell RAM that the display path scans.
- Returns one response pulse per command; the register slave exposes it as status and read-back data.

Parameters:
- GRID_ROWS, 16, number of grid rows (1..256)
- GRID_COLS, 16, number of grid columns (1..256)
- CELL_W, 4, bits per cell
- ADDR_W, 8, RAM address width; must satisfy 2^ADDR_W >= GRID_ROWS*GRID_COLS

Ports:
- ACLK  in  1  clock; all logic rising-edge
- ARESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_op  in  2  0=WRITE, 1=READ, 2=FILL, 3=CLEAR
- cmd_row  in  8  target row (WRITE/READ)
- cmd_col  in  8  target column (WRITE/READ)
- cmd_data  in  CELL_W  write/fill value
- ram_we  out  1  cell RAM write enable
- ram_re  out  1  cell RAM read enable
- ram_addr  out  ADDR_W  cell RAM address
- ram_wdata  out  CELL_W  cell RAM write data
- ram_rdata  in  CELL_W  cell RAM read data, valid 1 cycle after ram_re
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  CELL_W  read result
- rsp_err  out  1  command rejected; qualified by rsp_valid
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock ACLK; ARESET is asynchronous, active-high.
- Reset state: state=IDLE; all outputs 0 except cmd_ready=1.
- Output timing: all RAM and response outputs are registered.
- Handshake: a command is accepted on a rising edge with cmd_valid && cmd_ready.
  - cmd_ready = (state==IDLE).
  - All cmd_* fields are latched at acceptance; later changes are ignored.
- Address: addr = row*GRID_COLS + col, computed at full width, then truncated to ADDR_W.
- FSM states: IDLE, WRITE, RD_REQ, RD_WAIT, FILL, RESP.
- IDLE, on accept:
  - WRITE/READ with row>=GRID_ROWS or col>=GRID_COLS: go to RESP with rsp_err=1; no RAM access.
  - WRITE: go to WRITE.
  - READ: go to RD_REQ.
  - FILL: go to FILL with fill value = cmd_data.
  - CLEAR: go to FILL with fill value = 0.
  - FILL and CLEAR ignore row/col.
- WRITE: ram_we=1, ram_addr=addr, ram_wdata=data for exactly 1 cycle, then RESP.
- RD_REQ: ram_re=1, ram_addr=addr for 1 cycle, then RD_WAIT.
- RD_WAIT: capture ram_rdata into rsp_data, then RESP.
- FILL:
  - ram_we=1 every cycle; ram_addr runs 0,1,...,N-1 with N=GRID_ROWS*GRID_COLS.
  - After the cycle writing N-1, go to RESP.
  - No idle gaps; exactly N write cycles.
- RESP: rsp_valid=1 for 1 cycle, then IDLE. rsp_err is 1 only for a rejected command.
- rsp_data:
  - Updated only by a successful READ.
  - Holds its value through later WRITE, FILL and CLEAR commands.
  - Returns to 0 only on reset.
- Latency, with cycle 0 = accept edge:
  - WRITE: ram_we in cycle 1, rsp_valid in cycle 2.
  - READ: ram_re in cycle 1, capture in cycle 2, rsp_valid in cycle 3.
  - FILL/CLEAR: ram_we in cycles 1..N, rsp_valid in cycle N+1.
  - Rejected command: rsp_valid in cycle 1.
- Back-to-back: the next command can be accepted in the cycle after rsp_valid (IDLE). The minimum WRITE-to-WRITE accept spacing is 3 cycles.
- Mutual exclusion: ram_we and ram_re are never high together.
- Boundaries:
  - Last cell (row=GRID_ROWS-1, col=GRID_COLS-1) is legal.
  - Exactly row=GRID_ROWS or col=GRID_COLS is an error.
- Reset mid-operation: asserting ARESET during FILL, or any other state, immediately forces IDLE and deasserts ram_we/ram_re. A partial fill is not resumed and no rsp_valid is issued.

Test Plan:
- Reset behaviour: assert ARESET for 200 ns, release -> cmd_ready=1; busy, ram_we, ram_re, rsp_valid all 0.
- WRITE then READ: WRITE row=3 col=5 data=0xA -> ram_we for 1 cycle, addr=0x35, wdata=0xA, rsp_valid 2 cycles after accept, rsp_err=0. Then READ row=3 col=5 with RAM model returning 0xA -> rsp_valid 3 cycles after accept, rsp_data=0xA.
- FILL then CLEAR:
  - FILL data=0x7 -> exactly 256 consecutive ram_we cycles, addr 0x00..0xFF, wdata=0x7; rsp_valid at cycle 257; cmd_ready low throughout.
  - CLEAR -> same sequence with wdata=0.
- Range check: WRITE row=16 col=0 -> no ram_we, rsp_valid cycle 1 with rsp_err=1. READ row=15 col=15 -> addr=0xFF, rsp_err=0.
- Handshake hold-off: hold cmd_valid high with changing fields during a FILL -> nothing accepted until IDLE; the next command uses the fields present on its accept edge.
- Reset mid-fill: assert ARESET at fill address 0x40 -> ram_we drops asynchronously, no rsp_valid, cmd_ready=1 after release, rsp_data=0.
